pf_dispatch: RTL and testbench

PF_DISPATCH -- requirements
Module: pf_dispatch

---
 rtl/pf_dispatch.sv | 258 +++++++++++++++++++++++++
 tb/tb_pf_dispatch.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pf_dispatch.sv
// pf_dispatch: round-robin dispatcher between one snooper/forwarder pair and
// N_CORES packetfilter cores. There are two independent FSMs (SN and FWD).
// Each FSM offers the upstream/downstream side to one ready core, passes the
// ack through to that core, and routes the transfer strobes to it until done.
//
// Handshake: in OFFER, rdy_for_* is held high with sel frozen until the
// matching *_ack. The ack is passed combinationally to core bit sel only, and
// the FSM enters BUSY on that edge. Done is only honoured in BUSY. Done returns
// the FSM to IDLE and moves the pointer to sel+1.
//
// Optional feature: define PF_DISPATCH_STATS_EN to add the 32-bit packet
// counters sn_pkt_cnt / fwd_pkt_cnt.
// Debug: sn_state_o / fwd_state_o expose the FSM states (0=IDLE, 1=OFFER, 2=BUSY).
module pf_dispatch #(
  parameter int N_CORES           = 4,
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int INC_WIDTH         = 4,
  parameter int PLEN_WIDTH        = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  // upstream snooper
  input  logic [SN_FWD_ADDR_WIDTH-1:0]         sn_addr,
  input  logic [SN_FWD_DATA_WIDTH-1:0]         sn_wr_data,
  input  logic                                 sn_wr_en,
  input  logic [INC_WIDTH-1:0]                 sn_byte_inc,
  input  logic                                 sn_done,
  output logic                                 rdy_for_sn,
  input  logic                                 rdy_for_sn_ack,
  // core snooper side
  output logic [SN_FWD_ADDR_WIDTH-1:0]         core_sn_addr,
  output logic [SN_FWD_DATA_WIDTH-1:0]         core_sn_wr_data,
  output logic [INC_WIDTH-1:0]                 core_sn_byte_inc,
  output logic [N_CORES-1:0]                   core_sn_wr_en,
  output logic [N_CORES-1:0]                   core_sn_done,
  output logic [N_CORES-1:0]                   core_rdy_for_sn_ack,
  input  logic [N_CORES-1:0]                   core_rdy_for_sn,
  // downstream forwarder
  input  logic [SN_FWD_ADDR_WIDTH-1:0]         fwd_addr,
  input  logic                                 fwd_rd_en,
  output logic [SN_FWD_DATA_WIDTH-1:0]         fwd_rd_data,
  output logic                                 fwd_rd_data_vld,
  output logic [PLEN_WIDTH-1:0]                fwd_byte_len,
  input  logic                                 fwd_done,
  output logic                                 rdy_for_fwd,
  input  logic                                 rdy_for_fwd_ack,
  // core forwarder side
  output logic [SN_FWD_ADDR_WIDTH-1:0]         core_fwd_addr,
  output logic [N_CORES-1:0]                   core_fwd_rd_en,
  output logic [N_CORES-1:0]                   core_fwd_done,
  output logic [N_CORES-1:0]                   core_rdy_for_fwd_ack,
  input  logic [N_CORES*SN_FWD_DATA_WIDTH-1:0] core_fwd_rd_data,
  input  logic [N_CORES-1:0]                   core_fwd_rd_data_vld,
  input  logic [N_CORES*PLEN_WIDTH-1:0]        core_fwd_byte_len,
  input  logic [N_CORES-1:0]                   core_rdy_for_fwd,
  // debug
  output logic [1:0]                           sn_state_o,
  output logic [1:0]                           fwd_state_o
`ifdef PF_DISPATCH_STATS_EN
  ,
  output logic [31:0]                          sn_pkt_cnt,
  output logic [31:0]                          fwd_pkt_cnt
`endif
);

  localparam int SW = $clog2(N_CORES);
  localparam int W  = SN_FWD_DATA_WIDTH;
  localparam int PL = PLEN_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  // First ready core at or after ptr, wrapping modulo N_CORES.
  function automatic logic [SW-1:0] rr_pick(input logic [SW-1:0] ptr,
                                            input logic [N_CORES-1:0] rdy);
    logic [SW-1:0] pick;
    logic [SW:0]   idx;
    pick = ptr;
    // Scan from the farthest offset down so the nearest ready core wins.
    for (int k = N_CORES - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (SW+1)'(k);
      if (idx >= (SW+1)'(N_CORES)) idx = idx - (SW+1)'(N_CORES);
      if (rdy[idx[SW-1:0]]) pick = idx[SW-1:0];
    end
    return pick;
  endfunction

  // (sel + 1) mod N_CORES
  function automatic logic [SW-1:0] next_ptr(input logic [SW-1:0] s);
    logic [SW:0] n;
    n = {1'b0, s} + (SW+1)'(1);
    if (n >= (SW+1)'(N_CORES)) n = '0;
    return n[SW-1:0];
  endfunction

  state_e        sn_state_q, sn_state_d;
  logic [SW-1:0] sn_sel_q, sn_sel_d;
  logic [SW-1:0] sn_ptr_q, sn_ptr_d;
  state_e        fwd_state_q, fwd_state_d;
  logic [SW-1:0] fwd_sel_q, fwd_sel_d;
  logic [SW-1:0] fwd_ptr_q, fwd_ptr_d;

  // Broadcast buses simply follow the upstream/downstream inputs.
  assign core_sn_addr     = sn_addr;
  assign core_sn_wr_data  = sn_wr_data;
  assign core_sn_byte_inc = sn_byte_inc;
  assign core_fwd_addr    = fwd_addr;

  assign sn_state_o  = sn_state_q;
  assign fwd_state_o = fwd_state_q;

  // ---------------- SN FSM ----------------

  // SN state, select and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sn_state_q <= ST_IDLE;
      sn_sel_q   <= '0;
      sn_ptr_q   <= '0;
    end else begin
      sn_state_q <= sn_state_d;
      sn_sel_q   <= sn_sel_d;
      sn_ptr_q   <= sn_ptr_d;
    end
  end

  // SN next state: pick in IDLE, wait ack in OFFER, wait done in BUSY.
  always_comb begin
    sn_state_d = sn_state_q;
    sn_sel_d   = sn_sel_q;
    sn_ptr_d   = sn_ptr_q;
    case (sn_state_q)
      ST_IDLE: begin
        if (|core_rdy_for_sn) begin
          sn_sel_d   = rr_pick(sn_ptr_q, core_rdy_for_sn);
          sn_state_d = ST_OFFER;
        end
      end
      // A done arriving together with the ack is deliberately ignored here.
      ST_OFFER: if (rdy_for_sn_ack) sn_state_d = ST_BUSY;
      ST_BUSY: begin
        if (sn_done) begin
          sn_state_d = ST_IDLE;
          sn_ptr_d   = next_ptr(sn_sel_q);
        end
      end
      default: sn_state_d = ST_IDLE;
    endcase
  end

  // SN outputs: offer flag, ack pass-through and strobe routing to sel.
  always_comb begin
    rdy_for_sn          = 1'b0;
    core_rdy_for_sn_ack = '0;
    core_sn_wr_en       = '0;
    core_sn_done        = '0;
    if (sn_state_q == ST_OFFER) begin
      rdy_for_sn                    = 1'b1;
      core_rdy_for_sn_ack[sn_sel_q] = rdy_for_sn_ack;
    end
    if (sn_state_q == ST_BUSY) begin
      core_sn_wr_en[sn_sel_q] = sn_wr_en;
      core_sn_done[sn_sel_q]  = sn_done;
    end
  end

  // ---------------- FWD FSM ----------------

  // FWD state, select and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_state_q <= ST_IDLE;
      fwd_sel_q   <= '0;
      fwd_ptr_q   <= '0;
    end else begin
      fwd_state_q <= fwd_state_d;
      fwd_sel_q   <= fwd_sel_d;
      fwd_ptr_q   <= fwd_ptr_d;
    end
  end

  // FWD next state: same arbitration rules as SN, independent pointer.
  always_comb begin
    fwd_state_d = fwd_state_q;
    fwd_sel_d   = fwd_sel_q;
    fwd_ptr_d   = fwd_ptr_q;
    case (fwd_state_q)
      ST_IDLE: begin
        if (|core_rdy_for_fwd) begin
          fwd_sel_d   = rr_pick(fwd_ptr_q, core_rdy_for_fwd);
          fwd_state_d = ST_OFFER;
        end
      end
      ST_OFFER: if (rdy_for_fwd_ack) fwd_state_d = ST_BUSY;
      ST_BUSY: begin
        if (fwd_done) begin
          fwd_state_d = ST_IDLE;
          fwd_ptr_d   = next_ptr(fwd_sel_q);
        end
      end
      default: fwd_state_d = ST_IDLE;
    endcase
  end

  // FWD outputs: read data/len muxed from slice sel, zero outside BUSY.
  always_comb begin
    rdy_for_fwd          = 1'b0;
    core_rdy_for_fwd_ack = '0;
    core_fwd_rd_en       = '0;
    core_fwd_done        = '0;
    fwd_rd_data          = '0;
    fwd_rd_data_vld      = 1'b0;
    fwd_byte_len         = '0;
    if (fwd_state_q == ST_OFFER) begin
      rdy_for_fwd                     = 1'b1;
      core_rdy_for_fwd_ack[fwd_sel_q] = rdy_for_fwd_ack;
    end
    if (fwd_state_q == ST_BUSY) begin
      core_fwd_rd_en[fwd_sel_q] = fwd_rd_en;
      core_fwd_done[fwd_sel_q]  = fwd_done;
      fwd_rd_data     = core_fwd_rd_data[32'(fwd_sel_q)*W +: W];
      fwd_rd_data_vld = core_fwd_rd_data_vld[fwd_sel_q];
      fwd_byte_len    = core_fwd_byte_len[32'(fwd_sel_q)*PL +: PL];
    end
  end

`ifdef PF_DISPATCH_STATS_EN
  logic [31:0] sn_cnt_q, sn_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  // Packet counters advance on each done accepted in BUSY, wrapping naturally.
  always_comb begin
    sn_cnt_d  = sn_cnt_q;
    fwd_cnt_d = fwd_cnt_q;
    if (sn_state_q == ST_BUSY && sn_done)   sn_cnt_d  = sn_cnt_q + 32'd1;
    if (fwd_state_q == ST_BUSY && fwd_done) fwd_cnt_d = fwd_cnt_q + 32'd1;
  end

  // Packet counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sn_cnt_q  <= '0;
      fwd_cnt_q <= '0;
    end else begin
      sn_cnt_q  <= sn_cnt_d;
      fwd_cnt_q <= fwd_cnt_d;
    end
  end

  assign sn_pkt_cnt  = sn_cnt_q;
  assign fwd_pkt_cnt = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_pf_dispatch.sv
// tb_pf_dispatch: random and directed packets on the snooper and forwarder
// sides. A round-robin reference model predicts which core gets each packet.
// Monitors compare the DUT's ack, done and read-data outputs against queues of
// expected values.
module tb_pf_dispatch;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int W  = 64;
  localparam int IW = 4;
  localparam int PL = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]   sn_addr = '0;
  logic [W-1:0]    sn_wr_data = '0;
  logic            sn_wr_en = 1'b0;
  logic [IW-1:0]   sn_byte_inc = '0;
  logic            sn_done = 1'b0;
  logic            rdy_for_sn;
  logic            rdy_for_sn_ack = 1'b0;
  logic [AW-1:0]   core_sn_addr;
  logic [W-1:0]    core_sn_wr_data;
  logic [IW-1:0]   core_sn_byte_inc;
  logic [N-1:0]    core_sn_wr_en, core_sn_done, core_rdy_for_sn_ack;
  logic [N-1:0]    core_rdy_for_sn = '0;
  logic [AW-1:0]   fwd_addr = '0;
  logic            fwd_rd_en = 1'b0;
  logic [W-1:0]    fwd_rd_data;
  logic            fwd_rd_data_vld;
  logic [PL-1:0]   fwd_byte_len;
  logic            fwd_done = 1'b0;
  logic            rdy_for_fwd;
  logic            rdy_for_fwd_ack = 1'b0;
  logic [AW-1:0]   core_fwd_addr;
  logic [N-1:0]    core_fwd_rd_en, core_fwd_done, core_rdy_for_fwd_ack;
  logic [N*W-1:0]  core_fwd_rd_data = '0;
  logic [N-1:0]    core_fwd_rd_data_vld = '0;
  logic [N*PL-1:0] core_fwd_byte_len = '0;
  logic [N-1:0]    core_rdy_for_fwd = '0;
  logic [1:0]      sn_state_o, fwd_state_o;
`ifdef PF_DISPATCH_STATS_EN
  logic [31:0]     sn_pkt_cnt, fwd_pkt_cnt;
`endif

  pf_dispatch #(
    .N_CORES(N), .SN_FWD_ADDR_WIDTH(AW), .SN_FWD_DATA_WIDTH(W),
    .INC_WIDTH(IW), .PLEN_WIDTH(PL)
  ) dut (
    .clk(clk), .rst(rst),
    .sn_addr(sn_addr), .sn_wr_data(sn_wr_data), .sn_wr_en(sn_wr_en),
    .sn_byte_inc(sn_byte_inc), .sn_done(sn_done), .rdy_for_sn(rdy_for_sn),
    .rdy_for_sn_ack(rdy_for_sn_ack),
    .core_sn_addr(core_sn_addr), .core_sn_wr_data(core_sn_wr_data),
    .core_sn_byte_inc(core_sn_byte_inc), .core_sn_wr_en(core_sn_wr_en),
    .core_sn_done(core_sn_done), .core_rdy_for_sn_ack(core_rdy_for_sn_ack),
    .core_rdy_for_sn(core_rdy_for_sn),
    .fwd_addr(fwd_addr), .fwd_rd_en(fwd_rd_en), .fwd_rd_data(fwd_rd_data),
    .fwd_rd_data_vld(fwd_rd_data_vld), .fwd_byte_len(fwd_byte_len),
    .fwd_done(fwd_done), .rdy_for_fwd(rdy_for_fwd),
    .rdy_for_fwd_ack(rdy_for_fwd_ack),
    .core_fwd_addr(core_fwd_addr), .core_fwd_rd_en(core_fwd_rd_en),
    .core_fwd_done(core_fwd_done), .core_rdy_for_fwd_ack(core_rdy_for_fwd_ack),
    .core_fwd_rd_data(core_fwd_rd_data),
    .core_fwd_rd_data_vld(core_fwd_rd_data_vld),
    .core_fwd_byte_len(core_fwd_byte_len), .core_rdy_for_fwd(core_rdy_for_fwd),
    .sn_state_o(sn_state_o), .fwd_state_o(fwd_state_o)
`ifdef PF_DISPATCH_STATS_EN
    , .sn_pkt_cnt(sn_pkt_cnt), .fwd_pkt_cnt(fwd_pkt_cnt)
`endif
  );

  // ---------------- reference model / scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int sn_ptr_m  = 0;
  int fwd_ptr_m = 0;
  int sn_cnt_m  = 0;
  int fwd_cnt_m = 0;

  logic [N-1:0]    sn_ack_q[$];
  logic [N-1:0]    sn_done_q[$];
  logic [N-1:0]    fwd_ack_q[$];
  logic [N-1:0]    fwd_done_q[$];
  logic [PL+W-1:0] fwd_data_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round robin: first ready core at or after ptr, modulo N.
  function automatic int rr_model(input int ptr, input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Monitor: every ack/done/valid the DUT presents is popped and compared.
  always @(negedge clk) begin
    if (rst) begin
      if (core_rdy_for_sn_ack != '0) begin
        if (sn_ack_q.size() == 0) check("sn_ack_unexpected", core_rdy_for_sn_ack, 0);
        else check("sn_ack_core", core_rdy_for_sn_ack, sn_ack_q.pop_front());
      end
      if (core_sn_done != '0) begin
        if (sn_done_q.size() == 0) check("sn_done_unexpected", core_sn_done, 0);
        else check("sn_done_core", core_sn_done, sn_done_q.pop_front());
      end
      if (core_rdy_for_fwd_ack != '0) begin
        if (fwd_ack_q.size() == 0) check("fwd_ack_unexpected", core_rdy_for_fwd_ack, 0);
        else check("fwd_ack_core", core_rdy_for_fwd_ack, fwd_ack_q.pop_front());
      end
      if (core_fwd_done != '0) begin
        if (fwd_done_q.size() == 0) check("fwd_done_unexpected", core_fwd_done, 0);
        else check("fwd_done_core", core_fwd_done, fwd_done_q.pop_front());
      end
      if (fwd_rd_data_vld) begin
        if (fwd_data_q.size() == 0) check("fwd_vld_unexpected", 1, 0);
        else check("fwd_len_data", {fwd_byte_len, fwd_rd_data}, fwd_data_q.pop_front());
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with the SN FSM idle and no core ready.
  task automatic sn_packet(input logic [N-1:0] mask, input bit ack_with_done);
    int g;
    int wc;
    logic [N-1:0] oh;
    g  = rr_model(sn_ptr_m, mask);
    oh = onehot(g);
    core_rdy_for_sn = mask;
    @(posedge clk); #1;
    check("sn_offer_latency", rdy_for_sn, 1);
    wc = 0;
    while (!rdy_for_sn && wc < 20) begin @(posedge clk); #1; wc++; end
    if (!rdy_for_sn) begin
      check("sn_offer_timeout", rdy_for_sn, 1);
      core_rdy_for_sn = '0;
      return;
    end
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
      check("sn_offer_hold", rdy_for_sn, 1);
    end
    sn_ack_q.push_back(oh);
    rdy_for_sn_ack = 1'b1;
    if (ack_with_done) begin
      sn_done = 1'b1;
      #3;
      check("sn_ackdone_no_core_done", core_sn_done, 0);
    end
    @(posedge clk); #1;
    rdy_for_sn_ack  = 1'b0;
    sn_done         = 1'b0;
    core_rdy_for_sn = '0;
    check("sn_rdy_drop", rdy_for_sn, 0);
    repeat ($urandom_range(1, 3)) begin
      sn_addr     = AW'($urandom);
      sn_wr_data  = {$urandom, $urandom};
      sn_byte_inc = IW'($urandom);
      sn_wr_en    = 1'b1;
      #3;
      check("sn_wr_en_route", core_sn_wr_en, oh);
      check("sn_wr_data_bcast", core_sn_wr_data, sn_wr_data);
      @(posedge clk); #1;
    end
    sn_wr_en = 1'b0;
    sn_done_q.push_back(oh);
    sn_done = 1'b1;
    @(posedge clk); #1;
    sn_done  = 1'b0;
    sn_ptr_m = (g + 1) % N;
    sn_cnt_m++;
  endtask

  // Called at posedge+1 with the FWD FSM idle and no core ready.
  task automatic fwd_packet(input logic [N-1:0] mask, input bit len60);
    int g;
    int wc;
    logic [N-1:0]  oh;
    logic [W-1:0]  d[N];
    logic [PL-1:0] l[N];
    for (int i = 0; i < N; i++) begin
      d[i] = {$urandom, $urandom};
      l[i] = PL'($urandom_range(1, 9000));
    end
    if (len60) l[1] = 60;
    for (int i = 0; i < N; i++) begin
      core_fwd_rd_data[i*W +: W]    = d[i];
      core_fwd_byte_len[i*PL +: PL] = l[i];
    end
    g  = rr_model(fwd_ptr_m, mask);
    oh = onehot(g);
    core_rdy_for_fwd = mask;
    // Strobes outside BUSY must be ignored and valid suppressed.
    fwd_rd_en = 1'b1;
    core_fwd_rd_data_vld = '1;
    fwd_addr = AW'($urandom);
    @(posedge clk); #1;
    check("fwd_offer_latency", rdy_for_fwd, 1);
    wc = 0;
    while (!rdy_for_fwd && wc < 20) begin @(posedge clk); #1; wc++; end
    if (!rdy_for_fwd) begin
      check("fwd_offer_timeout", rdy_for_fwd, 1);
      core_rdy_for_fwd = '0;
      fwd_rd_en = 1'b0;
      core_fwd_rd_data_vld = '0;
      return;
    end
    check("fwd_rd_en_gated", core_fwd_rd_en, 0);
    check("fwd_addr_bcast", core_fwd_addr, fwd_addr);
    fwd_ack_q.push_back(oh);
    rdy_for_fwd_ack = 1'b1;
    @(posedge clk); #1;
    rdy_for_fwd_ack  = 1'b0;
    core_rdy_for_fwd = '0;
    check("fwd_rdy_drop", rdy_for_fwd, 0);
    fwd_data_q.push_back({l[g], d[g]});
    check("fwd_rd_en_route", core_fwd_rd_en, oh);
    if (len60) check("fwd_byte_len_60", fwd_byte_len, 60);
    @(posedge clk); #1;
    fwd_rd_en = 1'b0;
    core_fwd_rd_data_vld = '0;
    fwd_done_q.push_back(oh);
    fwd_done = 1'b1;
    @(posedge clk); #1;
    fwd_done  = 1'b0;
    fwd_ptr_m = (g + 1) % N;
    fwd_cnt_m++;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [N-1:0] m;
    // Reset state: strobes driven high must not leak while rst is low.
    sn_addr = 8'h5a;
    sn_wr_en = 1'b1;
    rdy_for_sn_ack = 1'b1;
    core_rdy_for_sn = '1;
    core_fwd_rd_data_vld = '1;
    core_fwd_byte_len = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy_for_sn", rdy_for_sn, 0);
    check("rst_rdy_for_fwd", rdy_for_fwd, 0);
    check("rst_core_sn_wr_en", core_sn_wr_en, 0);
    check("rst_core_sn_ack", core_rdy_for_sn_ack, 0);
    check("rst_fwd_vld", fwd_rd_data_vld, 0);
    check("rst_fwd_len", fwd_byte_len, 0);
    check("rst_sn_addr_bcast", core_sn_addr, 8'h5a);
    sn_wr_en = 1'b0;
    rdy_for_sn_ack = 1'b0;
    core_rdy_for_sn = '0;
    core_fwd_rd_data_vld = '0;
    rst = 1'b1;
    @(posedge clk); #1;

    // All cores ready: 0,1,2,3 then 0 again.
    repeat (5) sn_packet('1, 1'b0);
    // Only core 2 ready: from pointer 1, then again from pointer 3.
    sn_packet(4'b0100, 1'b0);
    sn_packet(4'b0100, 1'b0);
    // Forwarder on core 1 with length 60.
    fwd_packet(4'b0010, 1'b1);
    // Ack and done in the same OFFER cycle.
    sn_packet(N'($urandom_range(1, (1 << N) - 1)), 1'b1);

    // Reset during SN BUSY.
    core_rdy_for_sn = '1;
    @(posedge clk); #1;
    check("rstmid_offer", rdy_for_sn, 1);
    sn_ack_q.push_back(onehot(rr_model(sn_ptr_m, '1)));
    rdy_for_sn_ack = 1'b1;
    @(posedge clk); #1;
    rdy_for_sn_ack = 1'b0;
    core_rdy_for_sn = '0;
    sn_wr_en = 1'b1;
    #2;
    check("rstmid_busy_wr_en", core_sn_wr_en, onehot(rr_model(sn_ptr_m, '1)));
    rst = 1'b0;
    sn_done = 1'b1;
    #1;
    check("rstmid_rdy_for_sn", rdy_for_sn, 0);
    check("rstmid_core_wr_en", core_sn_wr_en, 0);
    check("rstmid_core_done", core_sn_done, 0);
    sn_wr_en = 1'b0;
    sn_done = 1'b0;
    sn_ptr_m = 0;
    fwd_ptr_m = 0;
    sn_cnt_m = 0;
    fwd_cnt_m = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    sn_packet('1, 1'b0);

    // Short burst for the packet counters: 3 snooper / 2 forwarded.
    sn_packet(N'($urandom_range(1, (1 << N) - 1)), 1'b0);
    sn_packet(N'($urandom_range(1, (1 << N) - 1)), 1'b0);
    fwd_packet(N'($urandom_range(1, (1 << N) - 1)), 1'b0);
    fwd_packet(N'($urandom_range(1, (1 << N) - 1)), 1'b0);
`ifdef PF_DISPATCH_STATS_EN
    check("stats_sn_3", sn_pkt_cnt, 32'(sn_cnt_m));
    check("stats_fwd_2", fwd_pkt_cnt, 32'(fwd_cnt_m));
`endif

    // Concurrent random traffic on both sides.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          m = N'($urandom_range(1, (1 << N) - 1));
          sn_packet(m, 1'($urandom_range(0, 1)));
          idle_gap();
        end
      end
      begin
        for (int j = 0; j < 30; j++) begin
          fwd_packet(N'($urandom_range(1, (1 << N) - 1)), 1'b0);
          idle_gap();
        end
      end
    join

    repeat (3) @(posedge clk);
    #1;
    check("sn_ack_q_drained", sn_ack_q.size(), 0);
    check("sn_done_q_drained", sn_done_q.size(), 0);
    check("fwd_ack_q_drained", fwd_ack_q.size(), 0);
    check("fwd_done_q_drained", fwd_done_q.size(), 0);
    check("fwd_data_q_drained", fwd_data_q.size(), 0);
`ifdef PF_DISPATCH_STATS_EN
    check("stats_sn_final", sn_pkt_cnt, 32'(sn_cnt_m));
    check("stats_fwd_final", fwd_pkt_cnt, 32'(fwd_cnt_m));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
